// File: rtl/ad9361_spi_arbiter_if.sv
// Requester-side bus of the AD9361 SPI arbiter: per-requester request fields
// packed into flat vectors, plus the shared grant/completion/read-data returns.
interface ad9361_spi_arbiter_if #(
  parameter int unsigned N_REQ = 3
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_wr;
  logic [10*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0]  req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [7:0]          rdata;
  logic                busy;

  // Requesters drive the request fields and observe the returns
  modport master (
    output req, req_wr, req_addr, req_wdata,
    input  gnt, done, rdata, busy
  );

  // The arbiter consumes the request fields and drives the returns
  modport slave (
    input  req, req_wr, req_addr, req_wdata,
    output gnt, done, rdata, busy
  );
endinterface

// File: rtl/ad9361_spi_arbiter.sv
// Round-robin arbiter that shares one AD9361 4-wire SPI port among N_REQ
// register-access requesters. Each grant runs one 24-bit single-byte transfer:
// {wr, 3'b000, 2'b00, addr[9:0], data[7:0]}, MSB first, sclk idle low.
module ad9361_spi_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  ad9361_spi_arbiter_if.slave  bus,
  output logic                 spi_cs,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [23:0]      shreg_q, shreg_d;
  logic [7:0]       rx_q, rx_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;

  logic [IdxW-1:0]  win;
  logic             found;
  int unsigned      cand;
  logic             win_wr;
  logic [9:0]       win_addr;
  logic [7:0]       win_data;
  logic [23:0]      win_word;
  logic [IdxW-1:0]  rr_next;

  // Round-robin search: first set request bit upward from the pointer, wrapping
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(rr_q) + i) % N_REQ;
      if (!found && bus.req[cand[IdxW-1:0]]) begin
        win   = cand[IdxW-1:0];
        found = 1'b1;
      end
    end
  end

  assign win_wr   = bus.req_wr[win];
  assign win_addr = bus.req_addr[32'(win) * 10 +: 10];
  // Reads always shift out a zero data byte
  assign win_data = win_wr ? bus.req_wdata[32'(win) * 8 +: 8] : 8'h00;
  assign win_word = {win_wr, 3'b000, 2'b00, win_addr, win_data};
  assign rr_next  = (32'(win) == N_REQ - 1) ? '0 : win + 1'b1;

  // Transaction sequencer: arbitration, SPI framing and completion
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;

    case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          owner_d    = win;
          wr_d       = win_wr;
          shreg_d    = win_word;
          mosi_d     = win_word[23];
          cs_d       = 1'b0;
          sclk_d     = 1'b0;
          busy_d     = 1'b1;
          div_d      = '0;
          rr_d       = rr_next;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising sclk: the slave's bit is sampled on this same edge
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], spi_miso};
          end else begin
            // Falling sclk: the only point where mosi may change
            sclk_d = 1'b0;
            if (bit_q == 5'd23) begin
              state_d = StHold;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = {shreg_q[22:0], 1'b0};
              mosi_d  = shreg_q[22];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StHold: begin
        if (div_q == DivLast) begin
          div_d           = '0;
          cs_d            = 1'b1;
          mosi_d          = 1'b0;
          done_d[owner_q] = 1'b1;
          // rx_q holds the last eight sampled bits, i.e. data bits 7..0
          if (!wr_q) begin
            rdata_d = rx_q;
          end
          state_d = StGap;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset; an abort drops the transfer
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      rx_q    <= '0;
      owner_q <= '0;
      wr_q    <= 1'b0;
      rr_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign spi_cs    = cs_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_ad9361_spi_arbiter.sv
// Directed bench for ad9361_spi_arbiter: a CLK_DIV=4 instance carries the main
// scenarios, a CLK_DIV=1 instance covers the fastest-divider corner.
module tb_ad9361_spi_arbiter;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  ad9361_spi_arbiter_if #(.N_REQ(3)) bus ();
  ad9361_spi_arbiter_if #(.N_REQ(3)) bus1 ();

  logic spi_cs, spi_sclk, spi_mosi, spi_miso;
  logic spi_cs1, spi_sclk1, spi_mosi1;
  logic spi_miso1 = 1'b0;

  ad9361_spi_arbiter #(.N_REQ(3), .CLK_DIV(4)) u_dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  ad9361_spi_arbiter #(.N_REQ(3), .CLK_DIV(1)) u_dut1 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus1),
    .spi_cs   (spi_cs1),
    .spi_sclk (spi_sclk1),
    .spi_mosi (spi_mosi1),
    .spi_miso (spi_miso1)
  );

  typedef struct {
    int          idx;
    logic [23:0] word;
    logic        rd;
    logic [7:0]  rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor state for the CLK_DIV=4 instance
  int          cyc = 0;
  int          low_cnt = 0;
  int          rcnt = 0;
  logic [23:0] mosi_word = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  int          done_cnt = 0;
  int          gnt_cnt[3] = '{0, 0, 0};
  int          cur_owner = 0;
  logic [7:0]  model_rdata = 8'h00;
  logic [7:0]  miso_tab[3] = '{8'h00, 8'h00, 8'h00};
  int          gnt_log_idx[$];
  int          gnt_log_cyc[$];
  int          rise_log_cyc[$];
  exp_t        e_mon;

  // MISO model: bits 7..0 of the slave byte on the last eight rising edges
  always_comb begin
    spi_miso = 1'b0;
    if (rcnt >= 16 && rcnt < 24) spi_miso = miso_tab[cur_owner][3'(23 - rcnt)];
  end

  // Sample one time unit after each edge; scoreboard pops on done
  always begin
    @(posedge sys_clk);
    #1;
    cyc++;
    check("inv_gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
    check("inv_done_onehot", 32'($onehot0(bus.done)), 32'd1);
    check("inv_gnt_and_done", 32'((|bus.gnt) && (|bus.done)), 32'd0);
    check("inv_sclk_while_cs_high", 32'(spi_sclk && spi_cs), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (bus.gnt[i]) begin
        gnt_cnt[i]++;
        cur_owner = i;
        gnt_log_idx.push_back(i);
        gnt_log_cyc.push_back(cyc);
      end
    end
    if (spi_cs && !prev_cs) rise_log_cyc.push_back(cyc);
    if (bus.done != 0) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        e_mon = sb.pop_front();
        check("done_vector", 32'(bus.done), 32'd1 << e_mon.idx);
        check("mosi_word", 32'(mosi_word), 32'(e_mon.word));
        check("sclk_rises", 32'(rcnt), 32'd24);
        check("cs_low_cycles", 32'(low_cnt), 32'd200);
        check("done_on_cs_rise", 32'(spi_cs && !prev_cs), 32'd1);
        check("rdata_at_done", 32'(bus.rdata), 32'(e_mon.rd ? e_mon.rdata : model_rdata));
        if (e_mon.rd) model_rdata = e_mon.rdata;
      end
    end
    if (!spi_cs) begin
      low_cnt++;
      if (spi_sclk && !prev_sclk) begin
        rcnt++;
        mosi_word = {mosi_word[22:0], spi_mosi};
      end
    end else begin
      low_cnt   = 0;
      rcnt      = 0;
      mosi_word = '0;
    end
    prev_cs   = spi_cs;
    prev_sclk = spi_sclk;
  end

  // Monitor state for the CLK_DIV=1 instance
  int          low1 = 0;
  int          rcnt1 = 0;
  int          hi_run1 = 0;
  logic [23:0] mosi1 = '0;
  logic        prev_sclk1 = 1'b0;
  int          done1_cnt = 0;
  int          gnt1_cnt = 0;
  int          low1_at_done = 0;
  int          rcnt1_at_done = 0;
  logic [23:0] mosi1_at_done = '0;

  always begin
    @(posedge sys_clk);
    #1;
    check("inv1_sclk_while_cs_high", 32'(spi_sclk1 && spi_cs1), 32'd0);
    if (bus1.gnt[0]) gnt1_cnt++;
    if (bus1.done != 0) begin
      done1_cnt++;
      low1_at_done  = low1;
      rcnt1_at_done = rcnt1;
      mosi1_at_done = mosi1;
    end
    if (spi_sclk1) begin
      hi_run1++;
    end else begin
      if (prev_sclk1) check("div1_sclk_high_width", 32'(hi_run1), 32'd1);
      hi_run1 = 0;
    end
    if (!spi_cs1) begin
      low1++;
      if (spi_sclk1 && !prev_sclk1) begin
        rcnt1++;
        mosi1 = {mosi1[22:0], spi_mosi1};
      end
    end else begin
      low1  = 0;
      rcnt1 = 0;
      mosi1 = '0;
    end
    prev_sclk1 = spi_sclk1;
  end

  task automatic issue(input int idx, input logic wr, input logic [9:0] addr,
                       input logic [7:0] wd, input logic [7:0] miso,
                       input logic [23:0] word, input bit push);
    exp_t e;
    bus.req_wr[idx]            = wr;
    bus.req_addr[idx*10 +: 10] = addr;
    bus.req_wdata[idx*8 +: 8]  = wd;
    miso_tab[idx]              = miso;
    if (push) begin
      e.idx   = idx;
      e.word  = word;
      e.rd    = !wr;
      e.rdata = miso;
      sb.push_back(e);
    end
    bus.req[idx] = 1'b1;
  endtask

  task automatic push_write(input int idx, input logic [23:0] word);
    exp_t e;
    e.idx   = idx;
    e.word  = word;
    e.rd    = 1'b0;
    e.rdata = 8'h00;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input int idx, input int budget);
    int base;
    int n;
    base = gnt_cnt[idx];
    n    = 0;
    while (gnt_cnt[idx] == base && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (gnt_cnt[idx] == base) check("timeout_gnt", 32'(gnt_cnt[idx]), 32'(base + 1));
    bus.req[idx] = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (done_cnt < target) check("timeout_done", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_rcnt(input int target, input int budget);
    int n;
    n = 0;
    while (rcnt < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (rcnt < target) check("timeout_bitcount", 32'(rcnt), 32'(target));
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst     = 1'b0;
    model_rdata = 8'h00;
  endtask

  task automatic clear_logs();
    gnt_log_idx.delete();
    gnt_log_cyc.delete();
    rise_log_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bus.req        = '0;
    bus.req_wr     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus1.req       = '0;
    bus1.req_wr    = '0;
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;

    // Reset values
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_cs_div1", 32'(spi_cs1), 32'd1);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Single write from requester 0
    issue(0, 1'b1, 10'h3F5, 8'hA5, 8'h00, 24'h83F5A5, 1'b1);
    wait_gnt(0, 20);
    wait_done(1, 400);
    check("write_rdata_unchanged", 32'(bus.rdata), 32'h00);

    // Single read from requester 1; wdata must not leak into the data field
    issue(1, 1'b0, 10'h037, 8'hEE, 8'h5C, 24'h003700, 1'b1);
    wait_gnt(1, 20);
    wait_done(2, 400);
    check("read_rdata", 32'(bus.rdata), 32'h5C);
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check("busy_after_done_cycles", 32'(n), 32'd4);

    // Round-robin fairness with all three requests held
    do_reset();
    clear_logs();
    base = done_cnt;
    issue(0, 1'b1, 10'h011, 8'h11, 8'h00, 24'h801111, 1'b1);
    issue(1, 1'b1, 10'h222, 8'h22, 8'h00, 24'h822222, 1'b1);
    issue(2, 1'b1, 10'h133, 8'h33, 8'h00, 24'h813333, 1'b1);
    push_write(0, 24'h801111);
    push_write(1, 24'h822222);
    push_write(2, 24'h813333);
    n = 0;
    while (gnt_log_idx.size() < 6 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    bus.req = '0;
    check("rr_grant_count", 32'(gnt_log_idx.size()), 32'd6);
    wait_done(base + 6, 400);
    for (int k = 0; k < 6; k++) begin
      if (k < gnt_log_idx.size()) check("rr_order", 32'(gnt_log_idx[k]), 32'(k % 3));
    end
    for (int k = 0; k < 5; k++) begin
      if (k + 1 < gnt_log_cyc.size() && k < rise_log_cyc.size())
        check("rr_grant_gap", 32'(gnt_log_cyc[k+1] - rise_log_cyc[k]), 32'd5);
    end

    // A request raised mid-shift waits for the current transfer
    clear_logs();
    base = done_cnt;
    issue(0, 1'b1, 10'h0AA, 8'h5A, 8'h00, 24'h80AA5A, 1'b1);
    wait_gnt(0, 20);
    wait_rcnt(6, 200);
    issue(2, 1'b0, 10'h155, 8'h00, 8'h3A, 24'h015500, 1'b1);
    wait_gnt(2, 400);
    wait_done(base + 2, 400);
    check("pend_grant_count", 32'(gnt_log_idx.size()), 32'd2);
    if (gnt_log_idx.size() >= 2 && rise_log_cyc.size() >= 1) begin
      check("pend_second_winner", 32'(gnt_log_idx[1]), 32'd2);
      check("pend_grant_gap", 32'(gnt_log_cyc[1] - rise_log_cyc[0]), 32'd5);
    end
    check("pend_rdata", 32'(bus.rdata), 32'h3A);

    // Reset during bit 10 of a read aborts it without a completion
    issue(1, 1'b0, 10'h0F0, 8'h00, 8'hC3, 24'h000000, 1'b0);
    wait_gnt(1, 20);
    wait_rcnt(10, 200);
    base    = done_cnt;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("abort_cs", 32'(spi_cs), 32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_mosi", 32'(spi_mosi), 32'd0);
    check("abort_rdata", 32'(bus.rdata), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    sys_rst     = 1'b0;
    model_rdata = 8'h00;
    repeat (30) @(negedge sys_clk);
    check("abort_no_done", 32'(done_cnt), 32'(base));

    // Pointer restarts at 0 so requester 1 beats requester 2
    clear_logs();
    issue(1, 1'b1, 10'h2C3, 8'h96, 8'h00, 24'h82C396, 1'b1);
    issue(2, 1'b1, 10'h001, 8'h01, 8'h00, 24'h800101, 1'b1);
    wait_gnt(1, 20);
    wait_gnt(2, 400);
    wait_done(base + 2, 400);
    if (gnt_log_idx.size() >= 1) check("post_reset_first_winner", 32'(gnt_log_idx[0]), 32'd1);
    check("post_reset_rdata", 32'(bus.rdata), 32'd0);

    // CLK_DIV=1 corner
    base              = done1_cnt;
    bus1.req_wr[0]    = 1'b1;
    bus1.req_addr[9:0] = 10'h000;
    bus1.req_wdata[7:0] = 8'hFF;
    bus1.req[0]       = 1'b1;
    n = 0;
    while (gnt1_cnt == 0 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    bus1.req[0] = 1'b0;
    check("div1_granted", 32'(gnt1_cnt), 32'd1);
    n = 0;
    while (done1_cnt == base && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (10) @(negedge sys_clk);
    check("div1_done_count", 32'(done1_cnt - base), 32'd1);
    check("div1_cs_low_cycles", 32'(low1_at_done), 32'd50);
    check("div1_sclk_rises", 32'(rcnt1_at_done), 32'd24);
    check("div1_mosi_word", 32'(mosi1_at_done), 32'h8000FF);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad9361_spi_arbiter.md
Name: ad9361_spi_arbiter

Overview:
- Shares the single AD9361 4-wire SPI port among N_REQ register-access requesters, e.g. the init sequencer, runtime LO retune and gain/AGC control.
- Arbitrates round-robin, then serialises one 24-bit single-byte AD9361 transaction: 16-bit instruction followed by 8 data bits.
- Returns read data and a per-requester completion pulse.
- Sits between the control logic and the ad9361_spi_cs/sclk/mosi/miso pins.

Parameters:
N_REQ, 3, number of requesters (2..8)
CLK_DIV, 4, sys_clk cycles per SCLK half-period (>=1)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
req  in  N_REQ  per-requester request level
req_wr  in  N_REQ  1 = write, 0 = read
req_addr  in  10*N_REQ  register address; requester k uses bits [10k+9:10k]
req_wdata  in  8*N_REQ  write data; requester k uses bits [8k+7:8k]
gnt  out  N_REQ  one-cycle accept pulse, one-hot
done  out  N_REQ  one-cycle completion pulse, one-hot
rdata  out  8  last read byte
busy  out  1  high from grant until return to IDLE
spi_cs  out  1  active-low chip select
spi_sclk  out  1  SPI clock, idle low
spi_mosi  out  1  serial data to AD9361
spi_miso  in  1  serial data from AD9361

Behaviour:
- Clock and reset: single clock domain sys_clk; reset is synchronous and active-high on sys_rst.
- Reset values: gnt=0, done=0, rdata=0, busy=0, spi_cs=1, spi_sclk=0, spi_mosi=0, rr pointer=0, state=IDLE.
- States: IDLE -> SETUP -> SHIFT (LO/HI phases) -> HOLD -> GAP -> IDLE.
- IDLE arbitration:
  - If req!=0, the winner is the first set bit searching upward from the rr pointer, wrapping.
  - At the next edge: gnt[winner]=1 for exactly one cycle; the requester's wr/addr/wdata are latched; spi_cs=0; busy=1; state=SETUP.
  - rr pointer becomes (winner+1) mod N_REQ.
- Requester contract:
  - Hold req/req_wr/req_addr/req_wdata stable until gnt.
  - req still high in the cycle after gnt counts as a new request.
  - req asserted while busy is held pending, not dropped.
- Shift word, MSB first: {wr, 3'b000 (one byte), 2'b00, addr[9:0], data[7:0]}. For reads the data field is 8'h00.
- SETUP: CLK_DIV cycles, spi_cs=0, spi_sclk=0, spi_mosi=bit23.
- SHIFT, 24 bits, each bit = CLK_DIV cycles sclk low then CLK_DIV cycles sclk high:
  - mosi changes only at the falling-edge boundary.
  - spi_miso is sampled on the sys_clk edge that drives sclk high.
  - Samples for bits 7..0 (the last 8 bits) form the read byte, MSB first.
- HOLD: CLK_DIV cycles, sclk=0, cs=0.
- Completion:
  - spi_cs goes high exactly (2+48)*CLK_DIV cycles after it fell.
  - On that same edge done[winner]=1 for one cycle.
  - For reads, rdata updates on that same edge and holds until the next read completes. Writes leave rdata unchanged.
- GAP: CLK_DIV cycles, cs high, then IDLE.
- Back-to-back throughput: next earliest grant = previous cs rise + CLK_DIV + 1 cycles.
- Invariants: at most one gnt bit and one done bit set; gnt and done never in the same cycle; spi_sclk never high while spi_cs=1.
- Reset mid-transaction:
  - Next edge: cs=1, sclk=0, mosi=0; state=IDLE; pointer=0.
  - No done is issued; rdata=0.
  - The aborted requester must re-request.
- CLK_DIV=1: each half-period is one cycle; cs low for 50 cycles.

Test Plan:
- Single write, CLK_DIV=4: req[0], wr=1, addr=0x3F5, wdata=0xA5 -> gnt[0] one cycle. MOSI over 24 rising sclk edges = 0x83F5A5. cs low exactly 200 cycles. done[0] on the cs rise edge. rdata stays 0x00.
- Single read: req[1], wr=0, addr=0x037; MISO model returns 0x5C on the last 8 bits -> MOSI word 0x003700. rdata=0x5C with done[1]. busy drops after GAP.
- Round-robin fairness: req=3'b111 held continuously -> grant order 0,1,2,0,1,2. Each grant follows the previous cs rise by 5 cycles (CLK_DIV=4). No requester is granted twice in a row.
- Pending during busy: req[2] raised mid-shift of requester 0's transaction -> not granted until IDLE. Then gnt[2] arrives with no glitch on cs/sclk.
- Reset mid-shift: assert sys_rst at bit 10 of a read -> next edge cs=1, sclk=0, mosi=0, rdata=0. No done pulse. After release, req=3'b110 grants requester 1 (pointer reset to 0).
- CLK_DIV=1 corner: write addr=0x000, wdata=0xFF -> cs low 50 cycles, 24 sclk pulses each 1 cycle high. MOSI=0x8000FF; done pulses once.
